// File: rtl/gemips_sram_pkg.sv
// rtl/gemips_sram_pkg.sv - shared types and constants for the BaseRAM arbiter and pin sequencer
// Contents: FSM state enum, port owner enum, default cycle counts, word-address slice [21:2].
package gemips_sram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_ACK
    } sram_state_e;

    typedef enum logic {
        OWNER_IF,
        OWNER_MEM
    } owner_e;

    localparam int RD_CYCLES_DEF = 2;
    localparam int WR_CYCLES_DEF = 2;

    localparam int ADDR_MSB = 21;
    localparam int ADDR_LSB = 2;
    localparam int SRAM_AW  = ADDR_MSB - ADDR_LSB + 1;

endpackage

// File: rtl/base_ram_arbiter_if.sv
// rtl/base_ram_arbiter_if.sv - CPU-side fetch and data request bundle for the BaseRAM arbiter
// master: driven by the core (requests, addresses, write data, byte enables).
// slave : driven by the arbiter (fetched word, read word, acks, stall).
interface base_ram_arbiter_if;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ack_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    logic        stall_o;

    modport master (
        output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_sel_i, mem_wdata_i,
        input  if_data_o, if_ack_o, mem_rdata_o, mem_ack_o, stall_o
    );

    modport slave (
        input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_addr_i, mem_sel_i, mem_wdata_i,
        output if_data_o, if_ack_o, mem_rdata_o, mem_ack_o, stall_o
    );
endinterface

// File: rtl/base_ram_port.sv
// rtl/base_ram_port.sv - single-requester BaseRAM pin sequencer (read / setup-pulse-hold write)
// In : clk, rst_n, req/we/addr/sel/wdata (sampled only in IDLE).
// Out: idle, ack (registered pulse), cap (read capture strobe), rdata (live bus value),
//      SRAM pins base_ram_data (inout), base_ram_addr, base_ram_be_n/ce_n/oe_n/we_n.
module base_ram_port
    import gemips_sram_pkg::*;
#(
    parameter int RD_CYCLES = RD_CYCLES_DEF,
    parameter int WR_CYCLES = WR_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req,
    input  logic               we,
    input  logic [SRAM_AW-1:0] addr,
    input  logic [3:0]         sel,
    input  logic [31:0]        wdata,
    output logic               idle,
    output logic               ack,
    output logic               cap,
    output logic [31:0]        rdata,
    inout  wire  [31:0]        base_ram_data,
    output logic [SRAM_AW-1:0] base_ram_addr,
    output logic [3:0]         base_ram_be_n,
    output logic               base_ram_ce_n,
    output logic               base_ram_oe_n,
    output logic               base_ram_we_n
);
    localparam logic [7:0] RD_LAST = 8'(RD_CYCLES - 1);
    localparam logic [7:0] WR_LAST = 8'(WR_CYCLES - 1);

    sram_state_e state_q, state_d;
    logic [7:0]  cnt_q;
    logic [3:0]  sel_q, sel_eff;
    logic [31:0] wdata_q;
    logic        drive_q;
    logic        ce_n_d, oe_n_d, we_n_d, drive_d;
    logic [3:0]  be_n_d;
    logic        grant;

    assign grant = (state_q == ST_IDLE) && req;
    assign idle  = (state_q == ST_IDLE);
    assign cap   = (state_q == ST_RD) && (cnt_q == RD_LAST);
    assign rdata = base_ram_data;
    assign base_ram_data = drive_q ? wdata_q : 32'bz;

    // Byte enables for the first write cycle come straight from the request,
    // since the latch is loaded on the same edge as the pins.
    assign sel_eff = (state_q == ST_IDLE) ? sel : sel_q;

    // Counter restarts on every state change, so it measures time spent in RD / WR_PULSE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (req) state_d = we ? ST_WR_SETUP : ST_RD;
            ST_RD:       if (cnt_q == RD_LAST) state_d = ST_ACK;
            ST_WR_SETUP: state_d = ST_WR_PULSE;
            ST_WR_PULSE: if (cnt_q == WR_LAST) state_d = ST_WR_HOLD;
            ST_WR_HOLD:  state_d = ST_ACK;
            ST_ACK:      state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Pin values are decoded from the next state and registered, so the pins
    // always match the state the FSM is in during that cycle.
    always_comb begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        be_n_d  = 4'hF;
        drive_d = 1'b0;
        case (state_d)
            ST_RD: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = 4'h0;
            end
            ST_WR_SETUP, ST_WR_HOLD: begin
                ce_n_d  = 1'b0;
                be_n_d  = ~sel_eff;
                drive_d = 1'b1;
            end
            ST_WR_PULSE: begin
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                be_n_d  = ~sel_eff;
                drive_d = 1'b1;
            end
            default: begin
                ce_n_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_ram_ce_n <= 1'b1;
            base_ram_oe_n <= 1'b1;
            base_ram_we_n <= 1'b1;
            base_ram_be_n <= 4'hF;
            base_ram_addr <= '0;
            drive_q       <= 1'b0;
            ack           <= 1'b0;
            sel_q         <= 4'h0;
            wdata_q       <= 32'h0;
        end else begin
            base_ram_ce_n <= ce_n_d;
            base_ram_oe_n <= oe_n_d;
            base_ram_we_n <= we_n_d;
            base_ram_be_n <= be_n_d;
            drive_q       <= drive_d;
            ack           <= (state_d == ST_ACK);
            if (grant) begin
                base_ram_addr <= addr;
                sel_q         <= sel;
                wdata_q       <= wdata;
            end
        end
    end
endmodule

// File: rtl/base_ram_arbiter.sv
// rtl/base_ram_arbiter.sv - fixed-priority fetch/data arbiter in front of the BaseRAM SRAM
// In : clk_50M, rst_n, cpu (slave side: fetch and data requests).
// Out: cpu acks, read data and stall; BaseRAM pins (data inout, addr, be_n, ce_n, oe_n, we_n).
module base_ram_arbiter
    import gemips_sram_pkg::*;
#(
    parameter int RD_CYCLES = RD_CYCLES_DEF,
    parameter int WR_CYCLES = WR_CYCLES_DEF
) (
    input  logic               clk_50M,
    input  logic               rst_n,
    base_ram_arbiter_if.slave  cpu,
    inout  wire  [31:0]        base_ram_data,
    output logic [SRAM_AW-1:0] base_ram_addr,
    output logic [3:0]         base_ram_be_n,
    output logic               base_ram_ce_n,
    output logic               base_ram_oe_n,
    output logic               base_ram_we_n
);
    owner_e             owner_q;
    logic               port_idle, port_ack, port_cap, port_req, port_we;
    logic [SRAM_AW-1:0] port_addr;
    logic [31:0]        port_rdata, if_data_q, mem_rdata_q;
    logic               unused_addr_bits;

    // Data port wins whenever it is requesting; the port only samples these in IDLE.
    assign port_req  = cpu.mem_req_i | cpu.if_req_i;
    assign port_we   = cpu.mem_req_i & cpu.mem_we_i;
    assign port_addr = cpu.mem_req_i ? cpu.mem_addr_i[ADDR_MSB:ADDR_LSB]
                                     : cpu.if_addr_i[ADDR_MSB:ADDR_LSB];
    assign unused_addr_bits = ^{cpu.mem_addr_i[31:ADDR_MSB+1], cpu.mem_addr_i[ADDR_LSB-1:0],
                                cpu.if_addr_i[31:ADDR_MSB+1], cpu.if_addr_i[ADDR_LSB-1:0]};

    base_ram_port #(
        .RD_CYCLES (RD_CYCLES),
        .WR_CYCLES (WR_CYCLES)
    ) u_port (
        .clk           (clk_50M),
        .rst_n         (rst_n),
        .req           (port_req),
        .we            (port_we),
        .addr          (port_addr),
        .sel           (cpu.mem_sel_i),
        .wdata         (cpu.mem_wdata_i),
        .idle          (port_idle),
        .ack           (port_ack),
        .cap           (port_cap),
        .rdata         (port_rdata),
        .base_ram_data (base_ram_data),
        .base_ram_addr (base_ram_addr),
        .base_ram_be_n (base_ram_be_n),
        .base_ram_ce_n (base_ram_ce_n),
        .base_ram_oe_n (base_ram_oe_n),
        .base_ram_we_n (base_ram_we_n)
    );

    // Separate read registers per requester: a write ack leaves mem_rdata_o untouched
    // and a fetch never disturbs the last data-port read.
    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            owner_q     <= OWNER_IF;
            if_data_q   <= 32'h0;
            mem_rdata_q <= 32'h0;
        end else begin
            if (port_idle && port_req)
                owner_q <= cpu.mem_req_i ? OWNER_MEM : OWNER_IF;
            if (port_cap) begin
                if (owner_q == OWNER_MEM) mem_rdata_q <= port_rdata;
                else                      if_data_q   <= port_rdata;
            end
        end
    end

    assign cpu.if_ack_o    = port_ack & (owner_q == OWNER_IF);
    assign cpu.mem_ack_o   = port_ack & (owner_q == OWNER_MEM);
    assign cpu.if_data_o   = if_data_q;
    assign cpu.mem_rdata_o = mem_rdata_q;
    assign cpu.stall_o     = (cpu.if_req_i & ~cpu.if_ack_o) | (cpu.mem_req_i & ~cpu.mem_ack_o);
endmodule

// File: tb/tb_base_ram_arbiter.sv
// tb/tb_base_ram_arbiter.sv - self-checking bench for base_ram_arbiter (default and RD=1/WR=3 instances)
module tb_base_ram_arbiter;
    import gemips_sram_pkg::*;

    localparam int RD1 = RD_CYCLES_DEF;
    localparam int WR1 = WR_CYCLES_DEF;
    localparam int RD2 = 1;
    localparam int WR2 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    base_ram_arbiter_if cpu1 ();
    base_ram_arbiter_if cpu2 ();

    wire  [31:0] ram1_data, ram2_data;
    logic [19:0] addr1, addr2;
    logic [3:0]  be1, be2;
    logic        ce1, oe1, we1, ce2, oe2, we2;

    base_ram_arbiter #(.RD_CYCLES(RD1), .WR_CYCLES(WR1)) dut1 (
        .clk_50M(clk), .rst_n(rst_n), .cpu(cpu1), .base_ram_data(ram1_data),
        .base_ram_addr(addr1), .base_ram_be_n(be1), .base_ram_ce_n(ce1),
        .base_ram_oe_n(oe1), .base_ram_we_n(we1));

    base_ram_arbiter #(.RD_CYCLES(RD2), .WR_CYCLES(WR2)) dut2 (
        .clk_50M(clk), .rst_n(rst_n), .cpu(cpu2), .base_ram_data(ram2_data),
        .base_ram_addr(addr2), .base_ram_be_n(be2), .base_ram_ce_n(ce2),
        .base_ram_oe_n(oe2), .base_ram_we_n(we2));

    // SRAM device models: drive the bus while selected and output-enabled,
    // store enabled bytes on every edge while we_n is low.
    logic [31:0] sram1 [256];
    logic [31:0] sram2 [256];
    logic        ld_en = 1'b0;
    logic [7:0]  ld_idx = 8'd0;
    logic [31:0] ld_val = 32'd0;

    assign ram1_data = (!ce1 && !oe1) ? sram1[addr1[7:0]] : 32'bz;
    assign ram2_data = (!ce2 && !oe2) ? sram2[addr2[7:0]] : 32'bz;

    always @(posedge clk) begin
        if (ld_en) begin
            sram1[ld_idx] <= ld_val;
            sram2[ld_idx] <= ld_val;
        end else begin
            if (!ce1 && !we1)
                for (int b = 0; b < 4; b++)
                    if (!be1[b]) sram1[addr1[7:0]][8*b +: 8] <= ram1_data[8*b +: 8];
            if (!ce2 && !we2)
                for (int b = 0; b < 4; b++)
                    if (!be2[b]) sram2[addr2[7:0]][8*b +: 8] <= ram2_data[8*b +: 8];
        end
    end

    // Transaction-level reference: word contents as the requester should see them.
    logic [31:0] init_val [256];
    logic [31:0] ref_mem  [256];
    logic [31:0] last_mem_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access on dut1 starting in an IDLE cycle; checks pins every cycle until ack.
    task automatic access(input bit is_mem, input bit we, input logic [31:0] addr,
                          input logic [3:0] sel, input logic [31:0] wd);
        int          lat_exp, cyc, we_low;
        bit          done, ack, other;
        logic [7:0]  idx;
        logic [3:0]  be_exp;
        logic [31:0] exp_rd;
        idx     = addr[9:2];
        be_exp  = ~sel;
        lat_exp = we ? WR1 + 3 : RD1 + 1;
        exp_rd  = ref_mem[idx];
        if (is_mem) begin
            cpu1.mem_req_i = 1'b1; cpu1.mem_we_i = we; cpu1.mem_addr_i = addr;
            cpu1.mem_sel_i = sel;  cpu1.mem_wdata_i = wd;
        end else begin
            cpu1.if_req_i = 1'b1; cpu1.if_addr_i = addr;
        end
        done = 1'b0; cyc = 0; we_low = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            ack   = is_mem ? cpu1.mem_ack_o : cpu1.if_ack_o;
            other = is_mem ? cpu1.if_ack_o  : cpu1.mem_ack_o;
            check("stall", 32'(cpu1.stall_o), 32'(cyc != lat_exp));
            check("we_oe_overlap", 32'(we1 | oe1), 32'd1);
            check("other_ack", 32'(other), 32'd0);
            if (!ce1) check("sram_addr", 32'(addr1), 32'(addr[21:2]));
            if (!we1) begin
                we_low++;
                check("be_n", 32'(be1), 32'(be_exp));
            end
            if (we && !ce1) check("wr_bus", ram1_data, wd);
            if (ack) begin
                done = 1'b1;
                check("latency", cyc, lat_exp);
                if (we) begin
                    check("we_pulse_width", we_low, WR1);
                    check("rdata_kept_on_write", cpu1.mem_rdata_o, last_mem_rd);
                    for (int b = 0; b < 4; b++)
                        if (sel[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
                end else if (is_mem) begin
                    check("mem_rdata", cpu1.mem_rdata_o, exp_rd);
                    last_mem_rd = exp_rd;
                end else begin
                    check("if_data", cpu1.if_data_o, exp_rd);
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) check("ack_timeout", 32'd0, 32'd1);
        cpu1.mem_req_i = 1'b0;
        cpu1.if_req_i  = 1'b0;
    endtask

    // Data-port access on the RD=1/WR=3 instance: latency and read data only.
    task automatic access2(input bit we, input logic [7:0] idx, input logic [31:0] wd,
                           input logic [31:0] exp_rd);
        int cyc;
        bit done;
        cpu2.mem_req_i = 1'b1; cpu2.mem_we_i = we; cpu2.mem_sel_i = 4'hF; cpu2.mem_wdata_i = wd;
        cpu2.mem_addr_i = 32'h8000_0000 | {22'd0, idx, 2'b00};
        done = 1'b0; cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            check("p2_we_oe_overlap", 32'(we2 | oe2), 32'd1);
            if (cpu2.mem_ack_o) begin
                done = 1'b1;
                check("p2_latency", cyc, we ? WR2 + 3 : RD2 + 1);
                if (!we) check("p2_rdata", cpu2.mem_rdata_o, exp_rd);
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) check("p2_ack_timeout", 32'd0, 32'd1);
        cpu2.mem_req_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          mcyc, icyc;
        bit          found;
        logic [31:0] wd2;

        cpu1.if_req_i = 1'b0; cpu1.if_addr_i = 32'h0; cpu1.mem_req_i = 1'b0; cpu1.mem_we_i = 1'b0;
        cpu1.mem_addr_i = 32'h0; cpu1.mem_sel_i = 4'h0; cpu1.mem_wdata_i = 32'h0;
        cpu2.if_req_i = 1'b0; cpu2.if_addr_i = 32'h0; cpu2.mem_req_i = 1'b0; cpu2.mem_we_i = 1'b0;
        cpu2.mem_addr_i = 32'h0; cpu2.mem_sel_i = 4'h0; cpu2.mem_wdata_i = 32'h0;
        last_mem_rd = 32'h0;

        for (int i = 0; i < 256; i++) init_val[i] = $urandom;
        init_val[4] = 32'h2402_0005;
        init_val[8] = 32'h1122_3344;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val[i];

        // Preload both SRAM models while the DUTs are held in reset.
        @(posedge clk); #1;
        ld_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ld_idx = 8'(i);
            ld_val = init_val[i];
            @(posedge clk); #1;
        end
        ld_en = 1'b0;

        @(negedge clk);
        check("rst_ce_n", 32'(ce1), 32'd1);
        check("rst_oe_n", 32'(oe1), 32'd1);
        check("rst_we_n", 32'(we1), 32'd1);
        check("rst_be_n", 32'(be1), 32'hF);
        check("rst_addr", 32'(addr1), 32'd0);
        check("rst_acks", 32'({cpu1.if_ack_o, cpu1.mem_ack_o}), 32'd0);
        check("rst_if_data", cpu1.if_data_o, 32'd0);
        check("rst_mem_rdata", cpu1.mem_rdata_o, 32'd0);
        check("rst2_ce_n", 32'(ce2), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fetch of word 4, then byte write to word 8 and read back.
        access(1'b0, 1'b0, 32'h8000_0010, 4'h0, 32'h0);
        access(1'b1, 1'b1, 32'h8000_0020, 4'b0010, 32'h0000_AB00);
        access(1'b1, 1'b0, 32'h8000_0020, 4'h0, 32'h0);
        access(1'b0, 1'b0, 32'h8000_0020, 4'h0, 32'h0);

        // Fetch and data read raised together: data first, fetch after one dead cycle.
        cpu1.mem_req_i = 1'b1; cpu1.mem_we_i = 1'b0; cpu1.mem_addr_i = 32'h8000_0040;
        cpu1.if_req_i = 1'b1; cpu1.if_addr_i = 32'h8000_0010;
        mcyc = -1; icyc = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("conf_both_acks", 32'(cpu1.mem_ack_o & cpu1.if_ack_o), 32'd0);
            if (cpu1.mem_ack_o) begin
                mcyc = c;
                check("conf_mem_data", cpu1.mem_rdata_o, ref_mem[16]);
                last_mem_rd = ref_mem[16];
            end
            if (cpu1.if_ack_o) begin
                icyc = c;
                check("conf_if_data", cpu1.if_data_o, ref_mem[4]);
            end
            @(posedge clk); #1;
            if (mcyc >= 0) cpu1.mem_req_i = 1'b0;
            if (icyc >= 0) cpu1.if_req_i  = 1'b0;
        end
        check("conf_mem_latency", mcyc, RD1 + 1);
        check("conf_if_latency", icyc, 2 * RD1 + 3);

        // Random mix of fetches, reads and writes over words 0..127.
        for (int n = 0; n < 200; n++) begin
            bit          m, w;
            logic [7:0]  idx;
            logic [3:0]  s;
            logic [31:0] d;
            m   = 1'($urandom_range(0, 1));
            w   = m & 1'($urandom_range(0, 1));
            idx = 8'($urandom_range(0, 127));
            s   = 4'($urandom_range(0, 15));
            d   = $urandom;
            access(m, w, 32'h8000_0000 | {22'd0, idx, 2'b00}, s, d);
        end

        // Reset asserted during the write pulse to word 255 (never read back).
        cpu1.mem_req_i = 1'b1; cpu1.mem_we_i = 1'b1; cpu1.mem_addr_i = 32'h8000_03FC;
        cpu1.mem_sel_i = 4'hF; cpu1.mem_wdata_i = $urandom;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (!we1) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("reached_we_pulse", 32'(found), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        cpu1.mem_req_i = 1'b0;
        @(negedge clk);
        check("abort_we_n", 32'(we1), 32'd1);
        check("abort_ce_n", 32'(ce1), 32'd1);
        check("abort_oe_n", 32'(oe1), 32'd1);
        check("abort_acks", 32'({cpu1.if_ack_o, cpu1.mem_ack_o}), 32'd0);
        check("abort_mem_rdata", cpu1.mem_rdata_o, 32'd0);
        last_mem_rd = 32'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        access(1'b1, 1'b0, 32'h8000_0014, 4'h0, 32'h0);
        access(1'b1, 1'b1, 32'h8000_0018, 4'b1001, $urandom);
        access(1'b1, 1'b0, 32'h8000_0018, 4'h0, 32'h0);

        // RD_CYCLES=1 / WR_CYCLES=3 instance.
        wd2 = $urandom;
        access2(1'b0, 8'd5, 32'h0, init_val[5]);
        access2(1'b1, 8'd200, wd2, 32'h0);
        access2(1'b0, 8'd200, 32'h0, wd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/base_ram_arbiter.md
# base_ram_arbiter

Shares the single BaseRAM SRAM between the instruction-fetch port and the data (MEM-stage) port of GeMIPS. It applies fixed-priority arbitration and sequences the multi-cycle SRAM read and write timing on the physical pins. It returns acknowledged data to each requester and raises a stall while any request is outstanding. It sits between the CPU core and the BaseRAM pins, in place of a permanent fetch-only mapping.

## Interface

**Parameters**
- `RD_CYCLES`, 2: cycles that `oe_n` stays low before read data is captured (≥1).
- `WR_CYCLES`, 2: width of the `we_n` low pulse in cycles (≥1).

**Ports** (one clock; reset is synchronous and active-low)
- `clk_50M` in 1: 50 MHz system clock; all state changes on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `if_req_i` in 1: fetch request; held high until `if_ack_o`.
- `if_addr_i` in 32: fetch byte address; bits [21:2] are used.
- `if_data_o` in/out: out 32: fetched word; valid while `if_ack_o`=1.
- `if_ack_o` out 1: one-cycle completion pulse.
- `mem_req_i` in 1: data request; held high until `mem_ack_o`.
- `mem_we_i` in 1: 1 = write, 0 = read.
- `mem_addr_i` in 32: data byte address; bits [21:2] are used.
- `mem_sel_i` in 4: active-high byte enables, applied on writes only.
- `mem_wdata_i` in 32: write data.
- `mem_rdata_o` out 32: read word; valid while `mem_ack_o`=1.
- `mem_ack_o` out 1: one-cycle completion pulse.
- `stall_o` out 1: combinational; `(if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o)`.
- `base_ram_data` inout 32: SRAM data bus.
- `base_ram_addr` out 20: SRAM word address.
- `base_ram_be_n`, `base_ram_ce_n`, `base_ram_oe_n`, `base_ram_we_n` out 4/1/1/1: SRAM controls, all active-low.

## Operation

**Arbitration (IDLE only)**
- If `mem_req_i`=1, the data port is granted. Otherwise, if `if_req_i`=1, the fetch port is granted.
- Fetch cannot starve: the data port drops its request after its ack, and the pipeline cannot issue another data request without a fetch.
- On grant, the arbiter latches the address (bits [21:2]), the write data, the byte enables and the owner.

**FSM states:** IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, ACK.
- IDLE → RD for a fetch, or for a data access with `mem_we_i`=0.
- IDLE → WR_SETUP for a data access with `mem_we_i`=1.
- RD → ACK after `RD_CYCLES` cycles.
- WR_SETUP → WR_PULSE (1 cycle).
- WR_PULSE → WR_HOLD after `WR_CYCLES` cycles.
- WR_HOLD → ACK (1 cycle).
- ACK → IDLE (1 cycle). Requests are ignored in ACK.

**Pin behaviour per state**
- RD: `ce_n`=0, `oe_n`=0, `we_n`=1, `be_n`=0000. Data is captured on the last RD edge.
- Write states: `ce_n`=0, `oe_n`=1, `be_n`=~sel. `we_n`=0 only in WR_PULSE.
- `base_ram_data` is driven with the latched write data only in WR_SETUP, WR_PULSE and WR_HOLD. It is high-Z in every other state.
- IDLE and ACK: `ce_n`=`oe_n`=`we_n`=1.

**Ack**
- ACK asserts the owner's ack together with its registered read data.
- On a write ack, `mem_rdata_o` keeps its previous value.

**Reset**
- Outputs go to: state IDLE, `ce_n`/`oe_n`/`we_n`=1, `be_n`=1111, `addr`=0, data bus high-Z, both acks 0, both data outputs 0.
- A reset mid-operation aborts the access on the next edge with no ack. A write pulse in progress ends with `we_n`=1 at that edge.

## Timing

- All pin controls and acks are registered. Only `stall_o` is combinational.
- Read, request first seen in IDLE at cycle T: pins active T+1 … T+`RD_CYCLES`; ack at T+`RD_CYCLES`+1. Latency is 3 cycles at default.
- Write, request at T: SETUP T+1; pulse T+2 … T+`WR_CYCLES`+1; HOLD next; ack at T+`WR_CYCLES`+3. Latency is 5 cycles at default.
- Address, `be_n` and write data are stable from SETUP through HOLD, so the SRAM sees setup and hold of ≥1 cycle (20 ns) around `we_n`.
- Requester rule: request signals must stay stable until the ack edge. In the cycle after ack, the request reflects the next access.
- Back-to-back requests: the next grant occurs in the IDLE cycle after ACK, so there is 1 dead cycle between accesses.
- Simultaneous fetch and data requests at T: data completes first. Fetch is granted at the IDLE following the data ACK.

## Structure

- Shared package `gemips_sram_pkg`:
  - FSM state enum.
  - `RD_CYCLES_DEF` and `WR_CYCLES_DEF`.
  - Address slice constants [21:2].
- Sub-module `base_ram_port`: owns the pin FSM, the cycle counter and the tri-state control, behind a single `req`/`we`/`ack` interface.
- `base_ram_arbiter` keeps only the grant logic, the owner latch, the ack routing and `stall_o`.

## Test plan

- Fetch read: `if_addr_i`=0x80000010, SRAM word 4 preloaded with 0x24020005 → `base_ram_addr`=0x00004, `if_ack_o` at T+3 with `if_data_o`=0x24020005, `stall_o` high T…T+2.
- Byte write: `mem_addr_i`=0x80000020, `mem_sel_i`=0010, `mem_wdata_i`=0x0000AB00 → `we_n` low for exactly 2 cycles with `be_n`=1101, bus driven only SETUP–HOLD. A subsequent read returns byte 1 = 0xAB with the other bytes unchanged.
- Conflict: `if_req_i` and `mem_req_i` (read 0x80000040) rise in the same cycle → `mem_ack_o` at T+3, `if_ack_o` at T+7, never both acks in one cycle.
- Bus discipline: random mix of 200 reads and writes → `base_ram_data` never driven while `oe_n`=0, and `we_n` and `oe_n` never low together.
- Reset mid-write: `rst_n`=0 during WR_PULSE → next edge `we_n`=1, `ce_n`=1, bus high-Z, no ack, state IDLE.
- Parameter sweep: `RD_CYCLES`=1, `WR_CYCLES`=3 → read ack at T+2, write ack at T+6.
